// File: rtl/game_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | game_pkg: shared constants and button FSM state encoding                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package game_pkg;

  localparam int GRID_SQUARES = 9;
  localparam int POS_IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARMING    = 2'b01,
    HELD      = 2'b10,
    RELEASING = 2'b11
  } btn_state_t;

endpackage
`default_nettype wire

// File: rtl/debounce_onepulse.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | debounce_onepulse: synchronizer + debounce FSM, one press_ok per press   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module debounce_onepulse
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_din,
  output logic o_db,
  output logic o_press_ok
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  btn_state_t             r_state;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
  end

  // Transitions fire at CNT_MAX, so the counter saturates without wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_s) begin
            r_state <= ARMING;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        ARMING: begin
          if (!w_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!w_s) begin
            r_state <= RELEASING;
            r_cnt   <= CNT_ONE;
          end
        end
        RELEASING: begin
          if (w_s) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_db       = (r_state == HELD) || (r_state == RELEASING);
  assign o_press_ok = (r_state == ARMING) && w_s && (r_cnt == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/move_input_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | move_input_conditioner: debounced X/O pulses and one-hot square select   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module move_input_conditioner
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_x_raw,
  input  logic                    btn_o_raw,
  input  logic [POS_IDX_W-1:0]    pos_sw_raw,
  output logic                    buttonX,
  output logic                    buttonO,
  output logic [GRID_SQUARES-1:0] sel_pos,
  output logic                    bad_sel
);

  logic [SYNC_STAGES-1:0][POS_IDX_W-1:0] r_sw_sync;
  logic [POS_IDX_W-1:0]    w_s_sw;
  logic                    w_press_x, w_press_o, w_db_x, w_db_o;
  logic                    w_any, w_valid;
  logic                    r_button_x, r_button_o, r_bad_sel;
  logic [GRID_SQUARES-1:0] r_sel_pos;

  debounce_onepulse #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_db_x (
    .clk        (clk),
    .reset      (reset),
    .i_din      (btn_x_raw),
    .o_db       (w_db_x),
    .o_press_ok (w_press_x)
  );

  debounce_onepulse #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_db_o (
    .clk        (clk),
    .reset      (reset),
    .i_din      (btn_o_raw),
    .o_db       (w_db_o),
    .o_press_ok (w_press_o)
  );

  always_ff @(posedge clk) begin
    if (reset) r_sw_sync <= '0;
    else       r_sw_sync <= {r_sw_sync[SYNC_STAGES-2:0], pos_sw_raw};
  end

  assign w_s_sw  = r_sw_sync[SYNC_STAGES-1];
  assign w_any   = w_press_x | w_press_o;
  assign w_valid = (w_s_sw <= POS_IDX_W'(GRID_SQUARES - 1));

  // The index is sampled only on an accepted press; simultaneous X/O loads once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_button_x <= 1'b0;
      r_button_o <= 1'b0;
      r_bad_sel  <= 1'b0;
      r_sel_pos  <= '0;
    end else begin
      r_button_x <= w_press_x & w_valid;
      r_button_o <= w_press_o & w_valid;
      r_bad_sel  <= w_any & ~w_valid;
      if (w_any && w_valid)
        r_sel_pos <= GRID_SQUARES'(1) << w_s_sw;
    end
  end

  assign buttonX = r_button_x;
  assign buttonO = r_button_o;
  assign bad_sel = r_bad_sel;
  assign sel_pos = r_sel_pos;

endmodule
`default_nettype wire

// File: tb/tb_move_input_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_move_input_conditioner: directed + random stimulus vs reference model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_move_input_conditioner;

  localparam int D = 16;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_x_raw = 1'b0;
  logic       btn_o_raw = 1'b0;
  logic [3:0] pos_sw_raw = 4'd0;
  logic       buttonX, buttonO, bad_sel;
  logic [8:0] sel_pos;

  always #5 clk = ~clk;

  move_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_x_raw  (btn_x_raw),
    .btn_o_raw  (btn_o_raw),
    .pos_sw_raw (pos_sw_raw),
    .buttonX    (buttonX),
    .buttonO    (buttonO),
    .sel_pos    (sel_pos),
    .bad_sel    (bad_sel)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: raw inputs delayed S cycles, then a level is accepted
  // once it has been seen for D consecutive synchronized cycles.
  logic       mhx [S];
  logic       mho [S];
  logic [3:0] mhsw[S];
  logic       mdbx = 1'b0, mdbo = 1'b0;
  int         r1x = 0, r0x = 0, r1o = 0, r0o = 0;
  logic       ebx = 1'b0, ebo = 1'b0, ebad = 1'b0;
  logic [8:0] esel = 9'd0;

  int tk = 0, nbx = 0, nbo = 0, nbad = 0, tbx = -1, tbo = -1, tbad = -1;

  task automatic db_model(input logic s, inout logic db, inout int r1, inout int r0,
                          output logic press);
    r1 = s ? r1 + 1 : 0;
    r0 = s ? 0 : r0 + 1;
    press = !db && s && (r1 == D);
    if (press) db = 1'b1;
    else if (db && !s && (r0 == D)) db = 1'b0;
  endtask

  task automatic model_step();
    logic sx, so, px, po;
    logic [3:0] ssw;
    if (reset) begin
      for (int i = 0; i < S; i++) begin
        mhx[i] = 1'b0; mho[i] = 1'b0; mhsw[i] = 4'd0;
      end
      mdbx = 1'b0; mdbo = 1'b0;
      r1x = 0; r0x = 0; r1o = 0; r0o = 0;
      ebx = 1'b0; ebo = 1'b0; ebad = 1'b0; esel = 9'd0;
    end else begin
      sx = mhx[S-1]; so = mho[S-1]; ssw = mhsw[S-1];
      db_model(sx, mdbx, r1x, r0x, px);
      db_model(so, mdbo, r1o, r0o, po);
      ebx = 1'b0; ebo = 1'b0; ebad = 1'b0;
      if (px || po) begin
        if (ssw <= 4'd8) begin
          esel = 9'd1 << ssw;
          ebx = px;
          ebo = po;
        end else begin
          ebad = 1'b1;
        end
      end
      for (int i = S - 1; i > 0; i--) begin
        mhx[i] = mhx[i-1]; mho[i] = mho[i-1]; mhsw[i] = mhsw[i-1];
      end
      mhx[0] = btn_x_raw; mho[0] = btn_o_raw; mhsw[0] = pos_sw_raw;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    tk++;
    chk("buttonX", int'(buttonX), int'(ebx));
    chk("buttonO", int'(buttonO), int'(ebo));
    chk("bad_sel", int'(bad_sel), int'(ebad));
    chk("sel_pos", int'(sel_pos), int'(esel));
    if (buttonX) begin nbx++; tbx = tk; end
    if (buttonO) begin nbo++; tbo = tk; end
    if (bad_sel) begin nbad++; tbad = tk; end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clr();
    tk = 0; nbx = 0; nbo = 0; nbad = 0; tbx = -1; tbo = -1; tbad = -1;
  endtask

  initial begin
    for (int i = 0; i < S; i++) begin
      mhx[i] = 1'b0; mho[i] = 1'b0; mhsw[i] = 4'd0;
    end

    // Reset state
    reset = 1'b1;
    run(3);
    chk("reset_sel", int'(sel_pos), 0);
    reset = 1'b0;
    run(5);

    // Clean X press at index 4
    pos_sw_raw = 4'd4;
    btn_x_raw = 1'b1;
    clr();
    run(40);
    chk("s1_count_x", nbx, 1);
    chk("s1_time_x", tbx, 18);
    chk("s1_count_o", nbo, 0);
    chk("s1_sel", int'(sel_pos), int'(9'b000010000));
    btn_x_raw = 1'b0;
    run(30);

    // O bounce never stable long enough
    clr();
    repeat (4) begin
      btn_o_raw = 1'b1; run(5);
      btn_o_raw = 1'b0; run(3);
    end
    run(30);
    chk("s2_count_o", nbo, 0);
    chk("s2_sel", int'(sel_pos), int'(9'b000010000));

    // Invalid index 10
    pos_sw_raw = 4'd10;
    btn_x_raw = 1'b1;
    clr();
    run(40);
    chk("s3_count_bad", nbad, 1);
    chk("s3_time_bad", tbad, 18);
    chk("s3_count_x", nbx, 0);
    chk("s3_sel", int'(sel_pos), int'(9'b000010000));
    btn_x_raw = 1'b0;
    run(30);

    // Simultaneous X and O at index 8
    pos_sw_raw = 4'd8;
    btn_x_raw = 1'b1;
    btn_o_raw = 1'b1;
    clr();
    run(40);
    chk("s4_time_x", tbx, 18);
    chk("s4_time_o", tbo, 18);
    chk("s4_sel", int'(sel_pos), int'(9'b100000000));
    btn_x_raw = 1'b0;
    btn_o_raw = 1'b0;
    run(30);

    // Reset mid-count with button held
    pos_sw_raw = 4'd2;
    btn_x_raw = 1'b1;
    clr();
    run(9);
    reset = 1'b1;
    run(1);
    chk("s5_rst_sel", int'(sel_pos), 0);
    chk("s5_rst_x", int'(buttonX), 0);
    reset = 1'b0;
    chk("s5_pre_count", nbx, 0);
    clr();
    run(40);
    chk("s5_count_x", nbx, 1);
    chk("s5_time_x", tbx, 18);
    btn_x_raw = 1'b0;
    run(30);

    // Switch moves without a press, then a fresh press
    pos_sw_raw = 4'd0;
    btn_o_raw = 1'b1;
    run(40);
    btn_o_raw = 1'b0;
    run(30);
    pos_sw_raw = 4'd7;
    run(100);
    chk("s6_hold_sel", int'(sel_pos), int'(9'b000000001));
    btn_o_raw = 1'b1;
    clr();
    run(40);
    chk("s6_count_o", nbo, 1);
    chk("s6_sel", int'(sel_pos), int'(9'b010000000));
    btn_o_raw = 1'b0;
    run(30);

    // Random segments with occasional reset pulses
    for (int seg = 0; seg < 60; seg++) begin
      btn_x_raw  = 1'($urandom_range(0, 1));
      btn_o_raw  = 1'($urandom_range(0, 1));
      pos_sw_raw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        run(1);
        reset = 1'b0;
      end
      run(int'($urandom_range(1, 30)));
    end
    btn_x_raw = 1'b0;
    btn_o_raw = 1'b0;
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
